ram_resp_l2: RTL and testbench

//  Memory-mapped RAM responder: the slave end of the req/ack/resp bus.

---
 rtl/ram_resp_l2_pkg.sv | 66 ++++++
 rtl/ram_resp_l2_rd_resp_pipe.sv | 43 ++++
 rtl/ram_resp_l2.sv | 158 +++++++++++++++
 tb/tb_ram_resp_l2.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_resp_l2_pkg.sv
// -----------------------------------------------------------------------------
// ram_resp_l2_pkg
// Shared definitions for the L2 req/ack/resp bus: bus widths, the request
// and read-beat record types, the ack FSM state names, and small helpers
// used by every slave on the bus (word-index slicing, byte-enable merge).
// -----------------------------------------------------------------------------
package ram_resp_l2_pkg;

    // Bus geometry shared with the address-split arbiter and the other slaves
    localparam int BUS_AW  = 32;
    localparam int BUS_DW  = 32;
    localparam int BUS_BEW = 4;

    // One request as presented on the bus while s_req is high
    typedef struct packed {
        logic               we;
        logic [BUS_AW-1:0]  addr;
        logic [BUS_BEW-1:0] be;
        logic [BUS_DW-1:0]  wdata;
    } bus_req_t;

    // One entry of the read-response delay line
    typedef struct packed {
        logic              valid;
        logic [BUS_DW-1:0] data;
    } rd_beat_t;

    // Ack FSM states; the state is carried by the wait counter itself
    // (zero = idle, non-zero = counting wait cycles)
    typedef enum logic [0:0] {
        ACK_ST_IDLE = 1'b0,
        ACK_ST_WAIT = 1'b1
    } ack_state_e;

    // Word index of a byte address for an array of 2**addr_w words.
    // The two byte-offset bits are dropped and every bit above the array
    // size is masked off, so addresses alias onto the array.
    function automatic logic [BUS_AW-1:0] word_index(
        input logic [BUS_AW-1:0] addr,
        input int unsigned       addr_w
    );
        logic [BUS_AW-1:0] mask;
        mask = (BUS_AW'(1'b1) << addr_w) - BUS_AW'(1'b1);
        return (addr >> 2'd2) & mask;
    endfunction

    // Replace each byte of old_w whose enable is set with the matching
    // byte of new_w; be == 0 returns old_w unchanged.
    function automatic logic [BUS_DW-1:0] be_merge(
        input logic [BUS_DW-1:0]  old_w,
        input logic [BUS_DW-1:0]  new_w,
        input logic [BUS_BEW-1:0] be
    );
        logic [BUS_DW-1:0] res;
        res = old_w;
        for (int i = 0; i < BUS_BEW; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_resp_l2_rd_resp_pipe.sv
// -----------------------------------------------------------------------------
// ram_resp_l2_rd_resp_pipe
// RD_LAT-deep delay line carrying read valid + data from the accept edge to
// the response cycle. Stages advance every cycle with no backpressure, so a
// beat entering in cycle N leaves in cycle N+RD_LAT and order is preserved.
//
// Ports
//   clk_i     in   clock, rising edge
//   rst_i     in   asynchronous active-high reset; clears every stage
//   beat_in   in   beat captured at the accept edge (data must be 0 when
//                  valid is 0, so the output data is 0 between responses)
//   beat_out  out  registered last stage
// -----------------------------------------------------------------------------
module ram_resp_l2_rd_resp_pipe
    import ram_resp_l2_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  rd_beat_t beat_in,
    output rd_beat_t beat_out
);

    rd_beat_t stage_r [RD_LAT];

    // Delay line: load stage 0, shift the rest down, clear on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= beat_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign beat_out = stage_r[RD_LAT-1];

endmodule

// File: rtl/ram_resp_l2.sv
// -----------------------------------------------------------------------------
// ram_resp_l2
// Memory-mapped RAM responder on the slave side of the L2 req/ack/resp bus.
// Serves word reads and byte-enabled writes to a 2**ADDR_W x 32 array, with a
// programmable number of ack wait states and pipelined in-order read
// responses.
//
// Parameters
//   ADDR_W    word-address width (array depth 2**ADDR_W)
//   RD_LAT    cycles from read accept to s_resp, >= 1
//   ACK_WAIT  cycles req must be held before ack is given, 0..15
//
// Ports
//   clk_i    in   clock
//   rst_i    in   asynchronous active-high reset
//   s_req    in   request, held with stable fields until ack
//   s_we     in   1 = write, 0 = read
//   s_addr   in   byte address; word index = s_addr[ADDR_W+1:2]
//   s_be     in   byte enables for writes
//   s_wdata  in   write data
//   s_ack    out  accept strobe (combinational); taken when req && ack
//   s_resp   out  one-cycle read-data-valid pulse
//   s_rdata  out  read data, 0 whenever s_resp is 0
// -----------------------------------------------------------------------------
module ram_resp_l2
    import ram_resp_l2_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int RD_LAT   = 1,
    parameter int ACK_WAIT = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               s_req,
    input  logic               s_we,
    input  logic [BUS_AW-1:0]  s_addr,
    input  logic [BUS_BEW-1:0] s_be,
    input  logic [BUS_DW-1:0]  s_wdata,
    output logic               s_ack,
    output logic               s_resp,
    output logic [BUS_DW-1:0]  s_rdata
);

    localparam int         DEPTH      = 2**ADDR_W;
    localparam logic [3:0] ACK_WAIT_C = 4'(ACK_WAIT);

    bus_req_t          req_s;
    logic [3:0]        wcnt_r;
    logic [3:0]        wcnt_nxt_s;
    ack_state_e        state_s;
    logic              ack_s;
    logic              wr_s;
    logic              rd_s;
    logic [ADDR_W-1:0] idx_s;
    logic [BUS_DW-1:0] mem_r [DEPTH];
    rd_beat_t          beat_in_s;
    rd_beat_t          beat_out_s;

    assign req_s = '{we: s_we, addr: s_addr, be: s_be, wdata: s_wdata};

    // Address bits above the array and the byte offset are discarded
    assign idx_s = ADDR_W'(word_index(req_s.addr, ADDR_W));

    // ---------------------------------------------------------------------
    // Ack FSM: the wait counter is the state. It counts cycles in which req
    // is held without ack and returns to zero on ack or when req drops, so
    // a withdrawn request pays the full wait again when it comes back.
    // ---------------------------------------------------------------------

    // Ack FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcnt_r <= 4'd0;
        end else begin
            wcnt_r <= wcnt_nxt_s;
        end
    end

    // Decode the counter into an FSM state for the next-state logic
    always_comb begin
        if (wcnt_r == 4'd0) begin
            state_s = ACK_ST_IDLE;
        end else begin
            state_s = ACK_ST_WAIT;
        end
    end

    // Ack FSM next-state logic
    always_comb begin
        wcnt_nxt_s = 4'd0;
        case (state_s)
            ACK_ST_IDLE: begin
                if (s_req && !ack_s) begin
                    wcnt_nxt_s = 4'd1;
                end else begin
                    wcnt_nxt_s = 4'd0;
                end
            end
            ACK_ST_WAIT: begin
                if (s_req && !ack_s) begin
                    wcnt_nxt_s = wcnt_r + 4'd1;
                end else begin
                    wcnt_nxt_s = 4'd0;
                end
            end
            default: begin
                wcnt_nxt_s = 4'd0;
            end
        endcase
    end

    // Ack FSM output: ack once the wait budget is used up; reset masks it
    // immediately so nothing can be accepted while rst_i is high
    always_comb begin
        if (s_req && (wcnt_r == ACK_WAIT_C) && !rst_i) begin
            ack_s = 1'b1;
        end else begin
            ack_s = 1'b0;
        end
    end

    assign s_ack = ack_s;

    // ack already implies req, so the bus fields are only looked at here
    assign wr_s = ack_s &&  req_s.we;
    assign rd_s = ack_s && !req_s.we;

    // Byte-enabled array write at the accept edge; contents are not reset
    always_ff @(posedge clk_i) begin
        if (wr_s) begin
            mem_r[idx_s] <= be_merge(mem_r[idx_s], req_s.wdata, req_s.be);
        end
    end

    // Read beat entering the pipe; data is forced to 0 when not a read so
    // s_rdata stays 0 outside response cycles
    always_comb begin
        if (rd_s) begin
            beat_in_s.valid = 1'b1;
            beat_in_s.data  = mem_r[idx_s];
        end else begin
            beat_in_s = '0;
        end
    end

    ram_resp_l2_rd_resp_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_resp_pipe (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .beat_in  (beat_in_s),
        .beat_out (beat_out_s)
    );

    assign s_resp  = beat_out_s.valid;
    assign s_rdata = beat_out_s.data;

endmodule

// File: tb/tb_ram_resp_l2.sv
// -----------------------------------------------------------------------------
// tb_ram_resp_l2
// Three responders share clock and reset:
//   dut 0: RD_LAT=1 ACK_WAIT=0   dut 1: RD_LAT=3 ACK_WAIT=0
//   dut 2: RD_LAT=1 ACK_WAIT=2
// A reference model (word array, held-cycle counters, response slots keyed
// by the cycle they are due) predicts ack/resp/rdata every cycle.
// -----------------------------------------------------------------------------
module tb_ram_resp_l2;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [ND];
    logic        we    [ND];
    logic [31:0] addr  [ND];
    logic [3:0]  be    [ND];
    logic [31:0] wdata [ND];
    logic        ack   [ND];
    logic        resp  [ND];
    logic [31:0] rdata [ND];

    always #5 clk = ~clk;

    ram_resp_l2 #(.ADDR_W(10), .RD_LAT(1), .ACK_WAIT(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .s_req(req[0]), .s_we(we[0]), .s_addr(addr[0]),
        .s_be(be[0]), .s_wdata(wdata[0]), .s_ack(ack[0]), .s_resp(resp[0]), .s_rdata(rdata[0]));
    ram_resp_l2 #(.ADDR_W(10), .RD_LAT(3), .ACK_WAIT(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .s_req(req[1]), .s_we(we[1]), .s_addr(addr[1]),
        .s_be(be[1]), .s_wdata(wdata[1]), .s_ack(ack[1]), .s_resp(resp[1]), .s_rdata(rdata[1]));
    ram_resp_l2 #(.ADDR_W(10), .RD_LAT(1), .ACK_WAIT(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .s_req(req[2]), .s_we(we[2]), .s_addr(addr[2]),
        .s_be(be[2]), .s_wdata(wdata[2]), .s_ack(ack[2]), .s_resp(resp[2]), .s_rdata(rdata[2]));

    // Driver intent per dut
    bit          drv_req   [ND];
    bit          drv_we    [ND];
    logic [31:0] drv_addr  [ND];
    logic [3:0]  drv_be    [ND];
    logic [31:0] drv_wdata [ND];

    // Reference model
    int          lat_m  [ND] = '{1, 3, 1};
    int          wait_m [ND] = '{0, 0, 2};
    logic [31:0] mem_m  [ND][1024];
    int          held_m [ND];
    bit          exp_v  [ND][8];
    logic [31:0] exp_d  [ND][8];
    bit          acc_m  [ND];
    int          cyc;

    // Last observed outputs
    logic        obs_ack   [ND];
    logic        obs_resp  [ND];
    logic [31:0] obs_rdata [ND];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            held_m[d] = 0;
            for (int s = 0; s < 8; s++) begin
                exp_v[d][s] = 1'b0;
                exp_d[d][s] = 32'h0;
            end
        end
    endtask

    // One bus cycle for all duts: drive, check, then advance the model
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            req[d] = drv_req[d];
            if (drv_req[d]) begin
                we[d] = drv_we[d]; addr[d] = drv_addr[d];
                be[d] = drv_be[d]; wdata[d] = drv_wdata[d];
            end else begin
                we[d] = 1'($urandom); addr[d] = $urandom;
                be[d] = 4'($urandom); wdata[d] = $urandom;
            end
        end
        #1;
        for (int d = 0; d < ND; d++) begin
            int s;
            s = cyc % 8;
            acc_m[d] = drv_req[d] && (held_m[d] >= wait_m[d]) && !rst;
            obs_ack[d] = ack[d]; obs_resp[d] = resp[d]; obs_rdata[d] = rdata[d];
            chk($sformatf("ack[%0d]", d), {31'b0, ack[d]}, {31'b0, acc_m[d]});
            chk($sformatf("resp[%0d]", d), {31'b0, resp[d]}, {31'b0, exp_v[d][s]});
            chk($sformatf("rdata[%0d]", d), rdata[d], exp_v[d][s] ? exp_d[d][s] : 32'h0);
            exp_v[d][s] = 1'b0;
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < ND; d++) begin
                if (acc_m[d]) begin
                    int idx;
                    idx = int'((drv_addr[d] >> 2) % 1024);
                    if (drv_we[d]) begin
                        for (int b = 0; b < 4; b++)
                            if (drv_be[d][b]) mem_m[d][idx][8*b +: 8] = drv_wdata[d][8*b +: 8];
                    end else begin
                        exp_v[d][(cyc + lat_m[d]) % 8] = 1'b1;
                        exp_d[d][(cyc + lat_m[d]) % 8] = mem_m[d][idx];
                    end
                end
                held_m[d] = (drv_req[d] && !acc_m[d]) ? held_m[d] + 1 : 0;
            end
        end
        cyc++;
    endtask

    // Single transaction on one dut, held until accepted (bounded)
    task automatic txn(input int d, input bit w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd);
        drv_req[d] = 1'b1; drv_we[d] = w; drv_addr[d] = a; drv_be[d] = b; drv_wdata[d] = wd;
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc_m[d]) break;
        end
        chk($sformatf("txn_ack[%0d]", d), {31'b0, obs_ack[d]}, 32'd1);
        drv_req[d] = 1'b0;
    endtask

    // Same write to every dut at once, each released when accepted
    task automatic write_all(input logic [31:0] a, input logic [31:0] wd);
        bit pend [ND];
        for (int d = 0; d < ND; d++) begin
            drv_req[d] = 1'b1; drv_we[d] = 1'b1; drv_addr[d] = a;
            drv_be[d] = 4'hF; drv_wdata[d] = wd; pend[d] = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            step();
            for (int d = 0; d < ND; d++)
                if (acc_m[d]) begin drv_req[d] = 1'b0; pend[d] = 1'b0; end
            if (!pend[0] && !pend[1] && !pend[2]) break;
        end
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("init_ack[%0d]", d), {31'b0, pend[d]}, 32'd0);
            drv_req[d] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cyc = 0;
        for (int d = 0; d < ND; d++) begin
            drv_req[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0;
            addr[d] = 32'h0; be[d] = 4'h0; wdata[d] = 32'h0;
            acc_m[d] = 1'b0;
        end
        model_reset();

        // Reset state
        step(); step();
        #2 rst = 1'b0;

        // Known contents for word indices 0..15
        for (int w = 0; w < 16; w++) write_all(32'(w * 4), $urandom);

        // Mid-operation asynchronous reset
        drv_req[0] = 1'b1; drv_we[0] = 1'b0; drv_addr[0] = 32'h0; drv_be[0] = 4'hF;
        drv_req[1] = 1'b1; drv_we[1] = 1'b0; drv_addr[1] = 32'h4; drv_be[1] = 4'hF;
        step();
        #2;
        chk("pre_rst_resp0", {31'b0, resp[0]}, 32'd1);
        chk("pre_rst_ack1", {31'b0, ack[1]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_ack1", {31'b0, ack[1]}, 32'd0);
        chk("rst_resp0", {31'b0, resp[0]}, 32'd0);
        chk("rst_rdata0", rdata[0], 32'h0);
        model_reset();
        drv_req[0] = 1'b0; drv_req[1] = 1'b0;
        step(); step();
        #2 rst = 1'b0;
        repeat (6) step();

        // Full write then read-after-write
        txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        txn(0, 1'b0, 32'h10, 4'hF, 32'h0);
        step();
        chk("t2_resp", {31'b0, obs_resp[0]}, 32'd1);
        chk("t2_rdata", obs_rdata[0], 32'hDEADBEEF);

        // Partial write
        txn(0, 1'b1, 32'h10, 4'b0101, 32'h11223344);
        txn(0, 1'b0, 32'h10, 4'hF, 32'h0);
        step();
        chk("t3_rdata", obs_rdata[0], 32'hDE22BE44);

        // Back-to-back reads, RD_LAT=3
        drv_req[1] = 1'b1; drv_we[1] = 1'b0; drv_be[1] = 4'hF;
        for (int k = 0; k < 3; k++) begin
            drv_addr[1] = 32'(k * 4);
            step();
            chk("t4_ack", {31'b0, obs_ack[1]}, 32'd1);
            chk("t4_no_early_resp", {31'b0, obs_resp[1]}, 32'd0);
        end
        drv_req[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_resp", {31'b0, obs_resp[1]}, 32'd1);
            chk("t4_data", obs_rdata[1], mem_m[1][k]);
        end
        step();
        chk("t4_resp_end", {31'b0, obs_resp[1]}, 32'd0);

        // Ack wait states, including a withdrawn request
        drv_req[2] = 1'b1; drv_we[2] = 1'b0; drv_addr[2] = 32'h8; drv_be[2] = 4'hF;
        step(); chk("t5_w0", {31'b0, obs_ack[2]}, 32'd0);
        step(); chk("t5_w1", {31'b0, obs_ack[2]}, 32'd0);
        step(); chk("t5_ack", {31'b0, obs_ack[2]}, 32'd1);
        step(); chk("t5_drop_w0", {31'b0, obs_ack[2]}, 32'd0);
        drv_req[2] = 1'b0;
        step();
        drv_req[2] = 1'b1;
        step(); chk("t5_re_w0", {31'b0, obs_ack[2]}, 32'd0);
        step(); chk("t5_re_w1", {31'b0, obs_ack[2]}, 32'd0);
        step(); chk("t5_re_ack", {31'b0, obs_ack[2]}, 32'd1);
        drv_req[2] = 1'b0;
        step();

        // Address aliasing and be=0 no-op
        txn(0, 1'b1, 32'h1000, 4'hF, 32'hA5A5A5A5);
        txn(0, 1'b0, 32'h0000, 4'hF, 32'h0);
        step();
        chk("t6_alias", obs_rdata[0], 32'hA5A5A5A5);
        txn(0, 1'b1, 32'h0000, 4'h0, 32'h0);
        txn(0, 1'b0, 32'h0000, 4'hF, 32'h0);
        step();
        chk("t6_be0", obs_rdata[0], 32'hA5A5A5A5);

        // Randomized traffic on all duts
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < ND; d++) begin
                if (drv_req[d] && !acc_m[d] && ($urandom_range(0, 7) == 0)) begin
                    drv_req[d] = 1'b0;
                end else if (!drv_req[d] || acc_m[d]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        logic [31:0] a;
                        a = $urandom;
                        a[11:6] = 6'd0;
                        drv_req[d] = 1'b1; drv_we[d] = 1'($urandom_range(0, 1));
                        drv_addr[d] = a; drv_be[d] = 4'($urandom); drv_wdata[d] = $urandom;
                    end else begin
                        drv_req[d] = 1'b0;
                    end
                end
            end
            step();
        end
        for (int d = 0; d < ND; d++) drv_req[d] = 1'b0;
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
